// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the external SRAM sequencer/arbiter.
// State encoding, default address width, wait-counter width and chip-select decode.
package sram_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD       = 3'd1,
      ST_WR_SETUP = 3'd2,
      ST_WR_PULSE = 3'd3,
      ST_WR_HOLD  = 3'd4,
      ST_ACK      = 3'd5
   } state_t;

   localparam int ADDR_SIZE_DEF = 21;
   localparam int WAIT_W        = 4;

   // Two chip bits to a one-cold active-low select vector.
   function automatic logic [3:0] cs_decode(input logic [1:0] chip);
      cs_decode = ~(4'b0001 << chip);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie the port that did not win last time is chosen.
// Purely combinational; the caller owns the last_grant register.
module rr_arb2 (
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
   output logic grant,
   output logic gnt_valid
);

   always_comb begin
      gnt_valid = req0 | req1;
      if (req0 && req1) begin
         grant = ~last_grant;
      end else begin
         grant = req1;
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter and cycle sequencer for an asynchronous 8-bit SRAM.
// Every pin is registered from the next state, so strobes change only on clock edges.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_SIZE = ADDR_SIZE_DEF,
   parameter int RD_WAIT   = 2,
   parameter int WR_PULSE  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req0,
   input  logic                 req1,
   input  logic                 we0,
   input  logic                 we1,
   input  logic [ADDR_SIZE-1:0] addr0,
   input  logic [ADDR_SIZE-1:0] addr1,
   input  logic [7:0]           wd0,
   input  logic [7:0]           wd1,
   output logic                 ack0,
   output logic                 ack1,
   output logic [7:0]           rdata,
   output logic [ADDR_SIZE-3:0] sram_addr,
   inout  wire  [7:0]           sram_dq,
   output logic [3:0]           sram_cs_n,
   output logic                 sram_oe_n,
   output logic                 sram_we_n,
   output state_t               dbg_state
);

   localparam logic [WAIT_W-1:0] RD_CNT = WAIT_W'(RD_WAIT - 1);
   localparam logic [WAIT_W-1:0] WR_CNT = WAIT_W'(WR_PULSE - 1);

   state_t                state, state_next;
   logic                  last_grant, grant, gnt_valid, sel_q;
   logic [1:0]            chip_q, chip_next;
   logic [7:0]            wd_q, wd_next, dq_out;
   logic                  dq_oe, access_next, drive_next;
   logic [WAIT_W-1:0]     cnt;
   logic                  cur_we;
   logic [ADDR_SIZE-1:0]  cur_addr;
   logic [7:0]            cur_wd;

   rr_arb2 u_rr (
      .req0       (req0),
      .req1       (req1),
      .last_grant (last_grant),
      .grant      (grant),
      .gnt_valid  (gnt_valid)
   );

   assign cur_we    = grant ? we1   : we0;
   assign cur_addr  = grant ? addr1 : addr0;
   assign cur_wd    = grant ? wd1   : wd0;
   assign sram_dq   = dq_oe ? dq_out : 8'hzz;
   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      chip_next  = chip_q;
      wd_next    = wd_q;
      case (state)
         ST_IDLE: begin
            if (gnt_valid) begin
               state_next = cur_we ? ST_WR_SETUP : ST_RD;
               chip_next  = cur_addr[ADDR_SIZE-1 -: 2];
               wd_next    = cur_wd;
            end
         end
         ST_RD:       if (cnt == '0) state_next = ST_ACK;
         ST_WR_SETUP: state_next = ST_WR_PULSE;
         ST_WR_PULSE: if (cnt == '0) state_next = ST_WR_HOLD;
         ST_WR_HOLD:  state_next = ST_ACK;
         ST_ACK:      state_next = ST_IDLE;
         default:     state_next = ST_IDLE;
      endcase
      access_next = state_next inside {ST_RD, ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD};
      drive_next  = state_next inside {ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= 1'b1;
         sel_q      <= 1'b0;
         chip_q     <= '0;
         wd_q       <= '0;
         cnt        <= '0;
         sram_addr  <= '0;
         rdata      <= '0;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         sram_cs_n  <= 4'hF;
         sram_oe_n  <= 1'b1;
         sram_we_n  <= 1'b1;
         dq_oe      <= 1'b0;
         dq_out     <= '0;
      end else begin
         chip_q <= chip_next;
         wd_q   <= wd_next;
         if (state == ST_IDLE && gnt_valid) begin
            last_grant <= grant;
            sel_q      <= grant;
            sram_addr  <= cur_addr[ADDR_SIZE-3:0];
            cnt        <= cur_we ? WR_CNT : RD_CNT;
         end else if ((state == ST_RD || state == ST_WR_PULSE) && cnt != '0) begin
            cnt <= cnt - WAIT_W'(1);
         end
         // Sample on the same edge that raises OE, while the SRAM still drives.
         if (state == ST_RD && cnt == '0) rdata <= sram_dq;
         sram_cs_n <= access_next ? cs_decode(chip_next) : 4'hF;
         sram_oe_n <= (state_next != ST_RD);
         sram_we_n <= (state_next != ST_WR_PULSE);
         dq_oe     <= drive_next;
         dq_out    <= wd_next;
         ack0      <= (state_next == ST_ACK) && !sel_q;
         ack1      <= (state_next == ST_ACK) && sel_q;
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM, vector table of single accesses, scoreboard
// on ack, plus round-robin and reset-abort sequences.
module tb_sram_arbiter;
   import sram_arb_pkg::*;

   localparam int AW  = 21;
   localparam int RDW = 2;
   localparam int WRP = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0, req1, we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [7:0]    wd0, wd1;
   logic          ack0, ack1;
   logic [7:0]    rdata;
   logic [AW-3:0] sram_addr;
   wire  [7:0]    sram_dq;
   logic [3:0]    sram_cs_n;
   logic          sram_oe_n, sram_we_n;
   state_t        dbg_state;

   int errors = 0;
   int checks = 0;
   logic [9:0] exp_q[$];   // {port, we, rdata}

   sram_arbiter #(.ADDR_SIZE(AW), .RD_WAIT(RDW), .WR_PULSE(WRP)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wd0(wd0), .wd1(wd1),
      .ack0(ack0), .ack1(ack1), .rdata(rdata),
      .sram_addr(sram_addr), .sram_dq(sram_dq), .sram_cs_n(sram_cs_n),
      .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // An undriven bus floats high.
   for (genvar i = 0; i < 8; i++) begin : g_pu
      pullup (sram_dq[i]);
   end

   // Behavioural SRAM
   logic [7:0] mem [logic [20:0]];
   logic [1:0] cs_idx;
   logic       cs_any;
   logic [7:0] mem_rd;

   always_comb begin
      cs_any = 1'b1;
      cs_idx = 2'd0;
      case (sram_cs_n)
         4'b1110: cs_idx = 2'd0;
         4'b1101: cs_idx = 2'd1;
         4'b1011: cs_idx = 2'd2;
         4'b0111: cs_idx = 2'd3;
         default: cs_any = 1'b0;
      endcase
   end

   always @(sram_cs_n or sram_oe_n or sram_we_n or sram_addr or cs_idx) begin
      if (mem.exists({cs_idx, sram_addr})) mem_rd = mem[{cs_idx, sram_addr}];
      else mem_rd = 8'h00;
   end

   assign sram_dq = (cs_any && !sram_oe_n && sram_we_n) ? mem_rd : 8'hzz;

   always @(posedge sram_we_n) begin
      if (!rst && cs_any) mem[{cs_idx, sram_addr}] = sram_dq;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: bus invariants, request-hold assertion, scoreboard on ack
   logic       req0_d = 1'b0, req1_d = 1'b0, ack0_d = 1'b0, ack1_d = 1'b0;
   logic [9:0] e;
   always @(negedge clk) begin
      if (!rst) begin
         chk("oe_we_overlap", {31'd0, !sram_oe_n && !sram_we_n}, 32'd0);
         chk("multi_cs", {31'd0, $countones(~sram_cs_n) > 1}, 32'd0);
         assert (!(req0_d && !req0 && !ack0_d)) else begin
            errors++; $display("FAIL req0_drop: req0 fell before ack0");
         end
         assert (!(req1_d && !req1 && !ack1_d)) else begin
            errors++; $display("FAIL req1_drop: req1 fell before ack1");
         end
         if (ack0 || ack1) begin
            if (ack0 && ack1) begin
               chk("two_acks", {30'd0, ack0, ack1}, 32'd1);
            end else if (exp_q.size() == 0) begin
               chk("unexpected_ack", {30'd0, ack1, ack0}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("ack_port", {31'd0, ack1}, {31'd0, e[9]});
               if (!e[8]) chk("rdata", {24'd0, rdata}, {24'd0, e[7:0]});
            end
         end
      end
      req0_d = req0; req1_d = req1; ack0_d = ack0; ack1_d = ack1;
   end

   typedef struct {
      logic          port;
      logic          we;
      logic [AW-1:0] addr;
      logic [7:0]    wd;
      logic [3:0]    exp_cs;
      logic [7:0]    exp_rdata;
   } vec_t;

   vec_t vecs [9];

   task automatic do_access(input vec_t v);
      int lat = -1, oe_cnt = 0, we_cnt = 0, dq_cnt = 0;
      logic [3:0]    cs_seen = 4'hF;
      logic [AW-3:0] addr_at_ack = '0;
      logic          dq_z_at_ack = 1'b0;
      int exp_lat = v.we ? 3 + WRP : 1 + RDW;
      @(posedge clk); #1;
      if (!v.port) begin req0 = 1; we0 = v.we; addr0 = v.addr; wd0 = v.wd; end
      else         begin req1 = 1; we1 = v.we; addr1 = v.addr; wd1 = v.wd; end
      exp_q.push_back({v.port, v.we, v.exp_rdata});
      for (int c = 0; c < 40 && lat < 0; c++) begin
         @(negedge clk);
         if (!sram_oe_n) oe_cnt++;
         if (!sram_we_n) we_cnt++;
         if (sram_oe_n && sram_dq == v.wd) dq_cnt++;
         if (sram_cs_n != 4'hF) cs_seen = sram_cs_n;
         if (v.port ? ack1 : ack0) begin
            lat = c;
            addr_at_ack = sram_addr;
            dq_z_at_ack = (sram_dq == 8'hFF);
         end
      end
      @(posedge clk); #1;
      if (!v.port) req0 = 0; else req1 = 0;
      chk("latency", lat, exp_lat);
      chk("cs_n", {28'd0, cs_seen}, {28'd0, v.exp_cs});
      chk("oe_low_cycles", oe_cnt, v.we ? 0 : RDW);
      chk("we_low_cycles", we_cnt, v.we ? WRP : 0);
      chk("dq_drive_cycles", dq_cnt, v.we ? WRP + 2 : 0);
      chk("dq_z_in_ack", {31'd0, dq_z_at_ack}, 32'd1);
      chk("sram_addr", {13'd0, addr_at_ack}, {13'd0, v.addr[AW-3:0]});
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1; req0 = 0; req1 = 0;
      repeat (2) @(posedge clk);
      #1 rst = 0;
   endtask

   int n0, n1;

   initial begin
      rst = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = '0; addr1 = '0; wd0 = '0; wd1 = '0;
      mem[21'h00A5F3] = 8'h3C;
      //         port  we    addr         wd     cs       rdata
      vecs[0] = '{1'b0, 1'b0, 21'h00A5F3, 8'h00, 4'b1110, 8'h3C};
      vecs[1] = '{1'b1, 1'b1, 21'h19C000, 8'hA5, 4'b0111, 8'h00};
      vecs[2] = '{1'b0, 1'b1, 21'h001234, 8'h5A, 4'b1110, 8'h00};
      vecs[3] = '{1'b0, 1'b0, 21'h001234, 8'h00, 4'b1110, 8'h5A};
      vecs[4] = '{1'b1, 1'b1, 21'h080001, 8'h96, 4'b1101, 8'h00};
      vecs[5] = '{1'b1, 1'b0, 21'h080001, 8'h00, 4'b1101, 8'h96};
      vecs[6] = '{1'b0, 1'b1, 21'h17FFFF, 8'hC3, 4'b1011, 8'h00};
      vecs[7] = '{1'b1, 1'b0, 21'h17FFFF, 8'h00, 4'b1011, 8'hC3};
      vecs[8] = '{1'b1, 1'b0, 21'h19C000, 8'h00, 4'b0111, 8'hA5};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cs_n", {28'd0, sram_cs_n}, 32'hF);
      chk("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
      chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
      chk("rst_dq_z", {24'd0, sram_dq}, 32'hFF);
      chk("rst_acks", {30'd0, ack1, ack0}, 32'd0);
      chk("rst_rdata", {24'd0, rdata}, 32'd0);
      chk("rst_sram_addr", {13'd0, sram_addr}, 32'd0);
      chk("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
      @(posedge clk); #1 rst = 0;

      for (int i = 0; i < 9; i++) do_access(vecs[i]);

      // Both ports hold read requests from reset: grants must alternate starting at port 0.
      do_reset();
      @(posedge clk); #1;
      we0 = 0; addr0 = 21'h00A5F3; we1 = 0; addr1 = 21'h19C000;
      exp_q.push_back({1'b0, 1'b0, 8'h3C});
      exp_q.push_back({1'b1, 1'b0, 8'hA5});
      exp_q.push_back({1'b0, 1'b0, 8'h3C});
      exp_q.push_back({1'b1, 1'b0, 8'hA5});
      req0 = 1; req1 = 1; n0 = 0; n1 = 0;
      for (int c = 0; c < 60 && (n0 < 2 || n1 < 2); c++) begin
         @(negedge clk);
         if (ack0) n0++;
         if (ack1) n1++;
         @(posedge clk); #1;
         if (n0 >= 2) req0 = 0;
         if (n1 >= 2) req1 = 0;
      end
      chk("rr_acks0", n0, 2);
      chk("rr_acks1", n1, 2);
      req0 = 0; req1 = 0;

      // Reset during the write pulse aborts the access without an ack.
      @(posedge clk); #1;
      req0 = 1; we0 = 1; addr0 = 21'h180010; wd0 = 8'h77;
      repeat (3) @(negedge clk);
      chk("abort_we_low", {31'd0, sram_we_n}, 32'd0);
      rst = 1; req0 = 0;
      @(negedge clk);
      chk("abort_cs_n", {28'd0, sram_cs_n}, 32'hF);
      chk("abort_we_n", {31'd0, sram_we_n}, 32'd1);
      chk("abort_oe_n", {31'd0, sram_oe_n}, 32'd1);
      chk("abort_dq_z", {24'd0, sram_dq}, 32'hFF);
      chk("abort_no_ack", {30'd0, ack1, ack0}, 32'd0);
      @(posedge clk); #1 rst = 0;
      repeat (4) @(negedge clk);
      chk("abort_idle_no_ack", {30'd0, ack1, ack0}, 32'd0);
      do_access(vecs[0]);
      do_access(vecs[6]);
      do_access(vecs[7]);

      repeat (3) @(posedge clk);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
